// File: rtl/adder_operand_feeder.sv
// Operand FIFO and issue sequencer in front of the 32-bit handshake adder.
// Issues one pair at a time, returns tagged sums, and drops hung operations.
module adder_operand_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int STARTUP = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_a,
    input  logic [31:0]              s_b,
    output logic [31:0]              add_in_a,
    output logic [31:0]              add_in_b,
    output logic                     add_i_valid,
    input  logic                     add_o_valid,
    input  logic [31:0]              add_sum,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [31:0]              r_sum,
    output logic [7:0]               r_tag,
    output logic                     err_timeout,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARTUP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_START,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t         state_q;
    logic [SW-1:0]  start_cnt_q;
    logic [TW-1:0]  wait_cnt_q;
    logic [7:0]     tag_q;
    logic [7:0]     itag_q;
    logic [31:0]    add_in_a_q;
    logic [31:0]    add_in_b_q;
    logic           add_i_valid_q;
    logic           r_valid_q;
    logic [31:0]    r_sum_q;
    logic [7:0]     r_tag_q;
    logic           err_q;

    logic [31:0]    mem_a_q [DEPTH];
    logic [31:0]    mem_b_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push_w;
    logic           issue_go;

    assign s_ready  = (count_q < CW'(DEPTH)) && (state_q != S_START);
    assign push_w   = s_valid && s_ready;
    // Issue only when the result register is empty or draining this cycle.
    assign issue_go = (state_q == S_IDLE) && (count_q != '0) &&
                      (!r_valid_q || r_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue_go) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_w && !issue_go) begin
            count_d = count_q + 1'b1;
        end else if (!push_w && issue_go) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_a_q[wr_ptr_q] <= s_a;
            mem_b_q[wr_ptr_q] <= s_b;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_START;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            tag_q         <= '0;
            itag_q        <= '0;
            add_in_a_q    <= '0;
            add_in_b_q    <= '0;
            add_i_valid_q <= 1'b0;
            r_valid_q     <= 1'b0;
            r_sum_q       <= '0;
            r_tag_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            add_i_valid_q <= 1'b0;
            if (r_valid_q && r_ready) begin
                r_valid_q <= 1'b0;
            end
            case (state_q)
                S_START: begin
                    if (start_cnt_q == SW'(STARTUP - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (issue_go) begin
                        state_q       <= S_ISSUE;
                        add_i_valid_q <= 1'b1;
                        add_in_a_q    <= mem_a_q[rd_ptr_q];
                        add_in_b_q    <= mem_b_q[rd_ptr_q];
                        itag_q        <= tag_q;
                        wait_cnt_q    <= '0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (add_o_valid) begin
                        r_sum_q   <= add_sum;
                        r_tag_q   <= itag_q;
                        r_valid_q <= 1'b1;
                        tag_q     <= tag_q + 1'b1;
                        state_q   <= S_IDLE;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        // Abandoned operation still consumes its tag.
                        err_q   <= 1'b1;
                        tag_q   <= tag_q + 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_START;
            endcase
        end
    end

    assign add_in_a    = add_in_a_q;
    assign add_in_b    = add_in_b_q;
    assign add_i_valid = add_i_valid_q;
    assign r_valid     = r_valid_q;
    assign r_sum       = r_sum_q;
    assign r_tag       = r_tag_q;
    assign err_timeout = err_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Directed bench for adder_operand_feeder with a two-cycle adder model.
// Each task drives one scenario and checks its own expected values.
module tb_adder_operand_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int STARTUP = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_a, s_b;
    logic [31:0] add_in_a, add_in_b;
    logic        add_i_valid;
    logic        add_o_valid;
    logic [31:0] add_sum;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_sum;
    logic [7:0]  r_tag;
    logic        err_timeout;
    logic [$clog2(DEPTH):0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int viol = 0;

    logic        en = 1'b1;
    logic        spur = 1'b0;
    logic        p1 = 1'b0;
    logic        ov = 1'b0;
    logic [31:0] sum1 = '0;
    logic [31:0] sumo = '0;

    int          iss_cyc[$];
    logic [31:0] got_sum[$];
    logic [7:0]  got_tag[$];

    adder_operand_feeder #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STARTUP(STARTUP)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_i_valid(add_i_valid), .add_o_valid(add_o_valid),
        .add_sum(add_sum),
        .r_valid(r_valid), .r_ready(r_ready), .r_sum(r_sum), .r_tag(r_tag),
        .err_timeout(err_timeout), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Adder model: i_valid in cycle t gives o_valid in cycle t+2.
    always @(posedge clk) begin
        p1 <= add_i_valid && en;
        if (add_i_valid) sum1 <= add_in_a + add_in_b;
        ov   <= p1;
        sumo <= sum1;
    end
    assign add_o_valid = ov | spur;
    assign add_sum     = sumo;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (add_i_valid) begin
            iss_cyc.push_back(cyc);
            if (r_valid && !r_ready) viol++;
        end
    end

    always @(posedge clk) begin
        if (resetn && r_valid && r_ready) begin
            got_sum.push_back(r_sum);
            got_tag.push_back(r_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_cyc.delete();
        got_sum.delete();
        got_tag.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        s_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        clear_logs();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        s_a = a;
        s_b = b;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            if (s_ready) ok = 1;
            #1;
        end
        s_valid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL push_accept: a=%h not accepted, required accept within 40 cycles", a);
        end
    endtask

    task automatic wait_results(input int n, input int maxc);
        for (int i = 0; i < maxc && got_sum.size() < n; i++) step();
        tests++;
        if (got_sum.size() < n) begin
            fails++;
            $display("FAIL wait_results: got %0d results, required %0d", got_sum.size(), n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        r_ready = 1'b1;
        step();
        step();
        step();
        tests++;
        if (s_ready !== 1'b0 || add_i_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: s_ready=%b add_i_valid=%b, required 0 0", s_ready, add_i_valid);
        end
        tests++;
        if (r_valid !== 1'b0 || r_sum !== 32'h0 || r_tag !== 8'h0) begin
            fails++;
            $display("FAIL reset_result: r_valid=%b r_sum=%h r_tag=%h, required 0 0 0", r_valid, r_sum, r_tag);
        end
        tests++;
        if (err_timeout !== 1'b0 || fifo_count !== '0) begin
            fails++;
            $display("FAIL reset_status: err=%b count=%0d, required 0 0", err_timeout, fifo_count);
        end
        tests++;
        if (add_in_a !== 32'h0 || add_in_b !== 32'h0) begin
            fails++;
            $display("FAIL reset_operands: a=%h b=%h, required 0 0", add_in_a, add_in_b);
        end
    endtask

    task automatic test_single();
        int rel;
        int rv_cyc = -1;
        resetn = 1'b1;
        rel = cyc;
        clear_logs();
        push(32'd5, 32'd7);
        tests++;
        if (fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL single_count1: count=%0d, required 1", fifo_count);
        end
        for (int i = 0; i < 20 && rv_cyc < 0; i++) begin
            step();
            if (r_valid) rv_cyc = cyc;
        end
        tests++;
        if (iss_cyc.size() != 1 || rv_cyc < 0) begin
            fails++;
            $display("FAIL single_issue: issues=%0d rv_cyc=%0d, required 1 issue and a result", iss_cyc.size(), rv_cyc);
        end else begin
            tests++;
            if (iss_cyc[0] - rel < STARTUP + 1) begin
                fails++;
                $display("FAIL single_startup: issue %0d cycles after release, required >= %0d", iss_cyc[0] - rel, STARTUP + 1);
            end
            tests++;
            if (rv_cyc - iss_cyc[0] != 3) begin
                fails++;
                $display("FAIL single_latency: latency=%0d, required 3", rv_cyc - iss_cyc[0]);
            end
        end
        tests++;
        if (add_in_a !== 32'd5 || add_in_b !== 32'd7) begin
            fails++;
            $display("FAIL single_operands: a=%0d b=%0d, required 5 7", add_in_a, add_in_b);
        end
        tests++;
        if (r_sum !== 32'd12 || r_tag !== 8'd0) begin
            fails++;
            $display("FAIL single_result: sum=%0d tag=%0d, required 12 0", r_sum, r_tag);
        end
        tests++;
        if (fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL single_count0: count=%0d, required 0", fifo_count);
        end
        step();
    endtask

    task automatic test_wrap();
        clear_logs();
        push(32'hFFFF_FFFF, 32'h0000_0002);
        push(32'h8000_0000, 32'h8000_0000);
        wait_results(2, 40);
        if (got_sum.size() >= 2) begin
            tests++;
            if (got_sum[0] !== 32'h1 || got_tag[0] !== 8'd1) begin
                fails++;
                $display("FAIL wrap_first: sum=%h tag=%0d, required 00000001 1", got_sum[0], got_tag[0]);
            end
            tests++;
            if (got_sum[1] !== 32'h0 || got_tag[1] !== 8'd2) begin
                fails++;
                $display("FAIL wrap_second: sum=%h tag=%0d, required 00000000 2", got_sum[1], got_tag[1]);
            end
        end
    endtask

    task automatic test_spurious();
        int n0;
        step();
        n0 = got_sum.size();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        step();
        tests++;
        if (r_valid !== 1'b0 || got_sum.size() != n0) begin
            fails++;
            $display("FAIL spurious: r_valid=%b extra=%0d, required 0 0", r_valid, got_sum.size() - n0);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        bit acc;
        do_reset();
        r_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(32'(i), 32'(10 * i));
        s_a = 32'd6;
        s_b = 32'd60;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || fifo_count !== 3'd4) begin
            fails++;
            $display("FAIL full_stall: s_ready high %0d cycles count=%0d, required 0 4", bad, fifo_count);
        end
        tests++;
        if (r_valid !== 1'b1 || r_sum !== 32'd11 || r_tag !== 8'd0 || iss_cyc.size() != 1) begin
            fails++;
            $display("FAIL full_held: rv=%b sum=%0d tag=%0d issues=%0d, required 1 11 0 1", r_valid, r_sum, r_tag, iss_cyc.size());
        end
        r_ready = 1'b1;
        for (int i = 0; i < 80 && got_sum.size() < 6; i++) begin
            @(posedge clk);
            acc = s_valid && s_ready;
            #1;
            if (acc) s_valid = 1'b0;
        end
        tests++;
        if (got_sum.size() != 6 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_drain: results=%0d s_valid=%b, required 6 0", got_sum.size(), s_valid);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (got_sum[i] !== 32'(11 * (i + 1)) || got_tag[i] !== 8'(i)) begin
                    fails++;
                    $display("FAIL full_order%0d: sum=%0d tag=%0d, required %0d %0d", i, got_sum[i], got_tag[i], 11 * (i + 1), i);
                end
            end
        end
        if (iss_cyc.size() == 6) begin
            for (int k = 2; k < 6; k++) begin
                tests++;
                if (iss_cyc[k] - iss_cyc[k-1] != 4) begin
                    fails++;
                    $display("FAIL full_spacing%0d: gap=%0d, required 4", k, iss_cyc[k] - iss_cyc[k-1]);
                end
            end
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL full_blocked_issue: %0d issues while blocked, required 0", viol);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int n0;
        step();
        clear_logs();
        r_ready = 1'b0;
        push(32'd100, 32'd23);
        push(32'hDEAD_BEEF, 32'h1111_1111);
        for (int i = 0; i < 20 && !r_valid; i++) step();
        n0 = iss_cyc.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (r_valid !== 1'b1 || r_sum !== 32'd123 || r_tag !== 8'd6) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
        end
        tests++;
        if (fifo_count !== 3'd1 || iss_cyc.size() != n0 || n0 != 1) begin
            fails++;
            $display("FAIL bp_hold: count=%0d issues=%0d, required 1 1", fifo_count, iss_cyc.size());
        end
        r_ready = 1'b1;
        wait_results(2, 40);
        if (got_sum.size() >= 2) begin
            tests++;
            if (got_sum[0] !== 32'd123 || got_tag[0] !== 8'd6 ||
                got_sum[1] !== 32'hEFBE_D000 || got_tag[1] !== 8'd7) begin
                fails++;
                $display("FAIL bp_drain: %h/%0d %h/%0d, required 0000007b/6 efbed000/7", got_sum[0], got_tag[0], got_sum[1], got_tag[1]);
            end
        end
    endtask

    task automatic test_timeout();
        int ec = -1;
        do_reset();
        r_ready = 1'b1;
        en = 1'b0;
        push(32'd3, 32'd4);
        for (int i = 0; i < 40 && ec < 0; i++) begin
            step();
            if (err_timeout) ec = cyc;
        end
        tests++;
        if (ec < 0 || iss_cyc.size() != 1) begin
            fails++;
            $display("FAIL to_flag: err_cyc=%0d issues=%0d, required flag and 1 issue", ec, iss_cyc.size());
        end else begin
            tests++;
            if (ec - iss_cyc[0] != TIMEOUT + 1) begin
                fails++;
                $display("FAIL to_time: delay=%0d, required %0d", ec - iss_cyc[0], TIMEOUT + 1);
            end
        end
        tests++;
        if (r_valid !== 1'b0) begin
            fails++;
            $display("FAIL to_drop: r_valid=%b, required 0", r_valid);
        end
        en = 1'b1;
        push(32'd8, 32'd9);
        wait_results(1, 40);
        if (got_sum.size() >= 1) begin
            tests++;
            if (got_sum[0] !== 32'd17 || got_tag[0] !== 8'd1 || err_timeout !== 1'b1) begin
                fails++;
                $display("FAIL to_next: sum=%0d tag=%0d err=%b, required 17 1 1", got_sum[0], got_tag[0], err_timeout);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b0;
        for (int i = 1; i <= 4; i++) push(32'(i), 32'(i));
        step();
        step();
        tests++;
        if (fifo_count !== 3'd3) begin
            fails++;
            $display("FAIL mid_queued: count=%0d, required 3", fifo_count);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if (fifo_count !== '0 || s_ready !== 1'b0 || add_i_valid !== 1'b0 ||
            add_in_a !== 32'h0 || r_valid !== 1'b0 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: count=%0d rdy=%b iv=%b a=%h rv=%b err=%b, required all 0", fifo_count, s_ready, add_i_valid, add_in_a, r_valid, err_timeout);
        end
        step();
        step();
        resetn = 1'b1;
        en = 1'b1;
        clear_logs();
        for (int i = 0; i < 12; i++) step();
        tests++;
        if (fifo_count !== '0 || iss_cyc.size() != 0) begin
            fails++;
            $display("FAIL mid_after: count=%0d issues=%0d, required 0 0", fifo_count, iss_cyc.size());
        end
        push(32'd20, 32'd22);
        wait_results(1, 40);
        if (got_sum.size() >= 1) begin
            tests++;
            if (got_sum[0] !== 32'd42 || got_tag[0] !== 8'd0) begin
                fails++;
                $display("FAIL mid_fresh: sum=%0d tag=%0d, required 42 0", got_sum[0], got_tag[0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_spurious();
        test_full();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_operand_feeder.md
Name: adder_operand_feeder

Overview:
Upstream stage for the 32-bit handshake adder. It buffers operand pairs from a producer through a valid/ready interface in a small FIFO. It issues one pair at a time to the adder as a single-cycle i_valid pulse, waits for the adder's o_valid, and returns the sum downstream on a valid/ready result port with a sequence tag. It also guards against a hung adder with a timeout.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, at least 2.
TIMEOUT, 15, maximum cycles in WAIT before abandoning an operation.
STARTUP, 2, cycles held in START after reset release before the first issue.

Ports:
clk  in  1  clock; all logic on its rising edge.
resetn  in  1  asynchronous active-low reset (assert async, deassert sync to clk).
s_valid  in  1  producer offers an operand pair.
s_ready  out  1  FIFO not full; transfer occurs when s_valid & s_ready.
s_a  in  32  first operand.
s_b  in  32  second operand.
add_in_a  out  32  operand A to the adder.
add_in_b  out  32  operand B to the adder.
add_i_valid  out  1  single-cycle issue pulse to the adder.
add_o_valid  in  1  adder result valid.
add_sum  in  32  adder result.
r_valid  out  1  result register holds a result.
r_ready  in  1  consumer accepts; transfer occurs when r_valid & r_ready.
r_sum  out  32  returned sum.
r_tag  out  8  sequence number of the returned result.
err_timeout  out  1  sticky; set on any timeout.
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn=0, immediate): state=START, FIFO empty, fifo_count=0, s_ready=0, add_i_valid=0, add_in_a/add_in_b=0, r_valid=0, r_sum=0, r_tag=0, err_timeout=0, issue tag counter=0, wait counter=0.
- s_ready=1 whenever fifo_count<DEPTH and state!=START. A push when full is impossible by construction.
- FIFO: pointers wrap modulo DEPTH. A simultaneous push and pop leaves the count unchanged. Bypass from s_* straight to issue is not allowed; minimum one cycle of FIFO residency.
- States:
  - START: count STARTUP cycles after reset release, then go to IDLE. This covers the adder's own idle-to-ready cycle.
  - IDLE: if fifo_count>0 and (r_valid=0 or r_ready=1), go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): add_i_valid=1; add_in_a/add_in_b = FIFO head; pop head; latch the issue tag; go to WAIT.
  - WAIT: wait counter increments each cycle.
    - On add_o_valid=1: r_sum<=add_sum, r_tag<=issued tag, r_valid<=1, tag counter +1 (wraps 255->0), go to IDLE.
    - If the counter reaches TIMEOUT without add_o_valid: err_timeout<=1, operation dropped, tag counter still +1, go to IDLE.
- add_in_a/add_in_b hold the last issued values outside ISSUE. add_i_valid is 0 in every state except ISSUE.
- Issue-to-result latency with the adder: i_valid at cycle t, o_valid at t+2, r_valid visible from t+3.
- Back-to-back throughput: one result every 4 cycles (ISSUE, WAIT, WAIT, IDLE).
- Result register: r_valid clears on r_valid & r_ready unless a new result loads in the same cycle, in which case it stays 1 with the new data. A new issue requires the result register to be free or draining, so an unconsumed result is never overwritten.
- add_o_valid outside WAIT is ignored (spurious).
- Adder arithmetic is modulo 2^32; the feeder passes add_sum through unmodified.
- Reset mid-operation (any state): everything returns to reset values and FIFO contents are discarded. err_timeout clears only on reset.

Test Plan:
- Reset then single op: push (a=5, b=7); the first add_i_valid occurs no earlier than STARTUP+1 cycles after reset release, and carries a=5, b=7. r_sum=12, r_tag=0 at i_valid+3. fifo_count goes 1 then 0.
- Wrap-around: push (0xFFFFFFFF, 0x00000002) -> r_sum=0x00000001. Push (0x80000000, 0x80000000) -> r_sum=0.
- Full FIFO: hold r_ready=0 and push 1+DEPTH+1 pairs (i=1..6, a=i, b=10*i). The first op completes into the result register, then 4 pairs fill the FIFO, fifo_count=4, s_ready=0, and the 6th is stalled. Release r_ready: sums 11,22,33,44,55,66 return in order with tags 0..5, no add_i_valid while r_valid=1 and r_ready=0, and 4-cycle spacing between issues.
- Back-pressure: r_ready=0 for 10 cycles with results pending -> r_sum/r_tag stable, no overwrite, then normal drain.
- Timeout: model adder never asserts o_valid -> err_timeout=1 after TIMEOUT WAIT cycles, next op issues with tag 1, err_timeout stays 1.
- Reset mid-WAIT with 3 entries queued -> all outputs at reset values immediately; after release, fifo_count=0 and no issue until a new push.
